// File: rtl/control_unit.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/write-back sequencing, memory-ready stalls, retire counter.
// Outputs decode combinationally from the registered state; stalls hold state in FETCH, MEM_READ and MEM_WRITE.
module control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             regiwrite,
  output logic             memtoreg,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcsrc,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'b0000,
    DECODE    = 4'b0001,
    EXEC_R    = 4'b0010,
    EXEC_I    = 4'b0011,
    MEM_ADDR  = 4'b0100,
    MEM_READ  = 4'b0101,
    WB_ALU    = 4'b0110,
    WB_MEM    = 4'b0111,
    MEM_WRITE = 4'b1000,
    BRANCH    = 4'b1001,
    ILLEGAL   = 4'b1111
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  state_t     state;
  state_t     state_nx;
  logic       is_store;
  logic       retire;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};
  assign estado            = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // MEM_ADDR must pick load vs store without looking at instr again, so remember it from DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store <= 1'b0;
    end else if (state == DECODE) begin
      is_store <= (opcode == OP_STORE);
    end
  end

  assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                  ((state == MEM_WRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      FETCH: begin
        if (mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        if (opcode == OP_R) begin
          state_nx = EXEC_R;
        end else if (opcode == OP_I) begin
          state_nx = EXEC_I;
        end else if ((opcode == OP_LOAD) && (funct3 == F3_W)) begin
          state_nx = MEM_ADDR;
        end else if ((opcode == OP_STORE) && (funct3 == F3_W)) begin
          state_nx = MEM_ADDR;
        end else if ((opcode == OP_BRANCH) && ((funct3 == F3_BEQ) || (funct3 == F3_BNE))) begin
          state_nx = BRANCH;
        end else begin
          state_nx = ILLEGAL;
        end
      end
      EXEC_R:    state_nx = WB_ALU;
      EXEC_I:    state_nx = WB_ALU;
      MEM_ADDR:  state_nx = is_store ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (mem_ready) state_nx = WB_MEM;
      end
      MEM_WRITE: begin
        if (mem_ready) state_nx = FETCH;
      end
      WB_ALU:    state_nx = FETCH;
      WB_MEM:    state_nx = FETCH;
      BRANCH:    state_nx = FETCH;
      ILLEGAL:   state_nx = ILLEGAL;
      default:   state_nx = ILLEGAL;
    endcase
  end

  // Output decode; reset forces every strobe low even though the state register already reads FETCH.
  always_comb begin
    regiwrite = 1'b0;
    memtoreg  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = 1'b0;
    alusrc    = 1'b0;
    aluop     = 2'b00;
    illegal   = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          memread = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        EXEC_R: begin
          aluop = 2'b10;
        end
        EXEC_I: begin
          aluop  = 2'b10;
          alusrc = 1'b1;
        end
        MEM_ADDR: begin
          alusrc = 1'b1;
        end
        MEM_READ: begin
          memread = 1'b1;
        end
        MEM_WRITE: begin
          memwrite = 1'b1;
        end
        WB_ALU: begin
          regiwrite = 1'b1;
        end
        WB_MEM: begin
          regiwrite = 1'b1;
          memtoreg  = 1'b1;
        end
        BRANCH: begin
          aluop = 2'b01;
          pcsrc = 1'b1;
          if (funct3 == F3_BEQ) begin
            pcwrite = zero;
          end else if (funct3 == F3_BNE) begin
            pcwrite = ~zero;
          end
        end
        ILLEGAL: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instruction streams checked cycle by cycle against a behavioural model.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic [3:0]  estado;
  logic        regiwrite, memtoreg, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, illegal;
  logic [1:0]  aluop;
  logic [31:0] instr_count;

  logic [3:0]  unused4_estado;
  logic        unused4_rw, unused4_mtr, unused4_mr, unused4_mw, unused4_irw, unused4_pcw;
  logic        unused4_pcs, unused4_asrc, unused4_ill;
  logic [1:0]  unused4_aluop;
  logic [3:0]  count4;

  int checks   = 0;
  int failures = 0;
  int rw_edges = 0;
  logic [31:0] total;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_ILL = 5;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .estado(estado), .regiwrite(regiwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
    .alusrc(alusrc), .aluop(aluop), .illegal(illegal), .instr_count(instr_count)
  );

  control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .estado(unused4_estado), .regiwrite(unused4_rw), .memtoreg(unused4_mtr), .memread(unused4_mr),
    .memwrite(unused4_mw), .irwrite(unused4_irw), .pcwrite(unused4_pcw), .pcsrc(unused4_pcs),
    .alusrc(unused4_asrc), .aluop(unused4_aluop), .illegal(unused4_ill), .instr_count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (regiwrite === 1'b1) rw_edges++;

  function automatic int classify(logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (op == 7'b0110011) return C_R;
    if (op == 7'b0010011) return C_I;
    if (op == 7'b0000011 && f3 == 3'b010) return C_LW;
    if (op == 7'b0100011 && f3 == 3'b010) return C_SW;
    if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) return C_BR;
    return C_ILL;
  endfunction

  // Required strobes {regiwrite,memtoreg,memread,memwrite,irwrite,pcwrite,pcsrc,alusrc,aluop,illegal}
  function automatic logic [10:0] exp_out(logic [3:0] st, bit rdy, bit z, logic [2:0] f3);
    bit rw = 0, mtr = 0, mr = 0, mw = 0, irw = 0, pcw = 0, pcs = 0, asrc = 0, ill = 0;
    logic [1:0] aop = 2'b00;
    case (st)
      4'b0000: begin mr = 1; irw = rdy; pcw = rdy; end
      4'b0010: aop = 2'b10;
      4'b0011: begin aop = 2'b10; asrc = 1; end
      4'b0100: asrc = 1;
      4'b0101: mr = 1;
      4'b0110: rw = 1;
      4'b0111: begin rw = 1; mtr = 1; end
      4'b1000: mw = 1;
      4'b1001: begin aop = 2'b01; pcs = 1; pcw = (f3 == 3'b000) ? z : !z; end
      4'b1111: ill = 1;
      default: ;
    endcase
    return {rw, mtr, mr, mw, irw, pcw, pcs, asrc, aop, ill};
  endfunction

  function automatic logic [31:0] rand_instr(int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      C_R:  return {($urandom % 2) ? 7'h20 : 7'h00, r[24:15], r[14:12], r[11:7], 7'b0110011};
      C_I:  return {r[31:15], r[14:12], r[11:7], 7'b0010011};
      C_LW: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
      C_SW: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
      default: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
    endcase
  endfunction

  // Drives one instruction from FETCH to the next FETCH, checking every cycle. Starts and ends at posedge+1.
  task automatic run_instr(input logic [31:0] ins, input bit z, input int fst, input int mst, input string tag);
    logic [3:0]  st_q[$];
    bit          rdy_q[$];
    int          cls, rw0;
    logic [10:0] got, exp;
    cls = classify(ins);
    repeat (fst) begin st_q.push_back(4'b0000); rdy_q.push_back(0); end
    st_q.push_back(4'b0000); rdy_q.push_back(1);
    st_q.push_back(4'b0001); rdy_q.push_back($urandom % 2);
    case (cls)
      C_R, C_I: begin
        st_q.push_back(cls == C_R ? 4'b0010 : 4'b0011); rdy_q.push_back($urandom % 2);
        st_q.push_back(4'b0110); rdy_q.push_back($urandom % 2);
      end
      C_LW, C_SW: begin
        st_q.push_back(4'b0100); rdy_q.push_back($urandom % 2);
        repeat (mst) begin st_q.push_back(cls == C_LW ? 4'b0101 : 4'b1000); rdy_q.push_back(0); end
        st_q.push_back(cls == C_LW ? 4'b0101 : 4'b1000); rdy_q.push_back(1);
        if (cls == C_LW) begin st_q.push_back(4'b0111); rdy_q.push_back($urandom % 2); end
      end
      default: begin
        st_q.push_back(4'b1001); rdy_q.push_back($urandom % 2);
      end
    endcase
    rw0 = rw_edges;
    foreach (st_q[i]) begin
      mem_ready = rdy_q[i];
      zero  = (st_q[i] == 4'b1001) ? z : 1'($urandom % 2);
      instr = (st_q[i] == 4'b0000) ? $urandom : ins;
      @(negedge clk);
      exp = exp_out(st_q[i], rdy_q[i], zero, ins[14:12]);
      got = {regiwrite, memtoreg, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop, illegal};
      checks += 2;
      if (estado !== st_q[i]) begin
        failures++;
        $display("FAIL %s estado cycle %0d: got %b want %b", tag, i, estado, st_q[i]);
      end
      if (got !== exp) begin
        failures++;
        $display("FAIL %s strobes cycle %0d (estado %b): got %b want %b", tag, i, st_q[i], got, exp);
      end
      @(posedge clk); #1;
    end
    total++;
    mem_ready = 1'b0;
    #1;
    checks += 4;
    if (estado !== 4'b0000) begin
      failures++; $display("FAIL %s return_to_fetch: got %b want 0000", tag, estado);
    end
    if (instr_count !== total) begin
      failures++; $display("FAIL %s instr_count: got %0d want %0d", tag, instr_count, total);
    end
    if (count4 !== total[3:0]) begin
      failures++; $display("FAIL %s instr_count4: got %0d want %0d", tag, count4, total[3:0]);
    end
    if ((rw_edges - rw0) !== ((cls <= C_LW) ? 1 : 0)) begin
      failures++; $display("FAIL %s regiwrite_edges: got %0d want %0d", tag, rw_edges - rw0, (cls <= C_LW) ? 1 : 0);
    end
  endtask

  // Pulses reset for two cycles and leaves the FSM in FETCH at posedge+1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (estado !== 4'b0000 || illegal !== 1'b0 || memread !== 1'b0) begin
      failures++; $display("FAIL %s in_reset: estado %b illegal %b memread %b want 0000 0 0", tag, estado, illegal, memread);
    end
    if (instr_count !== 32'd0 || count4 !== 4'd0) begin
      failures++; $display("FAIL %s reset_count: got %0d/%0d want 0", tag, instr_count, count4);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    total = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [10:0] got;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = 32'h0;
    total = 0;
    repeat (3) begin
      @(negedge clk);
      got = {regiwrite, memtoreg, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop, illegal};
      checks += 2;
      if (estado !== 4'b0000 || got !== 11'b0) begin
        failures++; $display("FAIL reset_outputs: estado %b strobes %b want 0000 0", estado, got);
      end
      if (instr_count !== 32'd0) begin
        failures++; $display("FAIL reset_count: got %0d want 0", instr_count);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (memread !== 1'b1 || irwrite !== 1'b1 || estado !== 4'b0000) begin
      failures++; $display("FAIL reset_release: memread %b irwrite %b estado %b want 1 1 0000", memread, irwrite, estado);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    run_instr(32'h002081B3, 1'b0, 0, 0, "add");
  endtask

  task automatic test_lw_stall;
    run_instr(32'h00402283, 1'b0, 0, 2, "lw_stall");
    run_instr(32'h0040A223, 1'b0, 2, 1, "sw_stall");
  endtask

  task automatic test_branch;
    run_instr(32'h00208463, 1'b1, 0, 0, "beq_taken");
    run_instr(32'h00208463, 1'b0, 0, 0, "beq_not_taken");
    run_instr(32'h00209463, 1'b0, 0, 0, "bne_taken");
    run_instr(32'h00209463, 1'b1, 0, 0, "bne_not_taken");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      run_instr(rand_instr($urandom_range(0, 4)), 1'($urandom % 2),
                $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_illegal;
    logic [31:0] bad [5];
    logic [10:0] got;
    logic [31:0] cnt0;
    bad[0] = 32'hFFFFFFFF;
    bad[1] = 32'h00400283;
    bad[2] = 32'h0040B223;
    bad[3] = 32'h0020C463;
    bad[4] = 32'h000012B7;
    for (int k = 0; k < 5; k++) begin
      run_instr(32'h00100093, 1'b0, 0, 0, "pre_illegal");
      cnt0 = total;
      mem_ready = 1'b1; instr = $urandom;
      @(posedge clk); #1;
      instr = bad[k];
      @(negedge clk);
      checks++;
      if (estado !== 4'b0001) begin
        failures++; $display("FAIL illegal_decode %0d: got %b want 0001", k, estado);
      end
      @(posedge clk); #1;
      repeat (10) begin
        mem_ready = 1'($urandom % 2);
        @(negedge clk);
        got = {regiwrite, memtoreg, memread, memwrite, irwrite, pcwrite, pcsrc, alusrc, aluop, illegal};
        checks += 2;
        if (estado !== 4'b1111 || got !== 11'b00000000001) begin
          failures++; $display("FAIL illegal_hold %0d: estado %b strobes %b want 1111 00000000001", k, estado, got);
        end
        if (instr_count !== cnt0) begin
          failures++; $display("FAIL illegal_count %0d: got %0d want %0d", k, instr_count, cnt0);
        end
        @(posedge clk); #1;
      end
      do_reset("illegal_reset");
      @(negedge clk);
      checks++;
      if (illegal !== 1'b0 || estado !== 4'b0000) begin
        failures++; $display("FAIL illegal_cleared: illegal %b estado %b want 0 0000", illegal, estado);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset;
    int rw0;
    run_instr(32'h00100093, 1'b0, 0, 0, "pre_mid_reset");
    mem_ready = 1'b1; instr = $urandom;
    @(posedge clk); #1;
    instr = 32'h002081B3;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (estado !== 4'b0110) begin
      failures++; $display("FAIL mid_reset_setup: got %b want 0110", estado);
    end
    rw0 = rw_edges;
    rst_n = 1'b0;
    #1;
    checks++;
    if (regiwrite !== 1'b0 || estado !== 4'b0000 || instr_count !== 32'd0) begin
      failures++; $display("FAIL mid_reset_abort: regiwrite %b estado %b count %0d want 0 0000 0", regiwrite, estado, instr_count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rw_edges !== rw0 || instr_count !== 32'd0) begin
      failures++; $display("FAIL mid_reset_no_wb: edges %0d count %0d want %0d 0", rw_edges, instr_count, rw0);
    end
    rst_n = 1'b1; mem_ready = 1'b0; total = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    do_reset("wrap_reset");
    for (int n = 0; n < 17; n++) begin
      run_instr(rand_instr($urandom_range(0, 4)), 1'($urandom % 2), 0, $urandom_range(0, 1), "wrap");
    end
    checks += 2;
    if (count4 !== 4'd1) begin
      failures++; $display("FAIL wrap_cnt4: got %0d want 1", count4);
    end
    if (instr_count !== 32'd17) begin
      failures++; $display("FAIL wrap_cnt32: got %0d want 17", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_random();
    test_illegal();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
